mult_error_sweeper: RTL and testbench
=====================================

# mult_error_sweeper

Hardware stimulus and analysis engine for the approximate-multiplier top level on the Nexys4 board. On `start` it sweeps every operand pair (A, B) over the full N-bit range and drives the pairs into the multiplier. It reads back the exact product, approximate product, percent error and error flag for each pair, and accumulates error statistics for display or readout. It is the on-chip counterpart of the simulation bench: it generates operands, consumes the multiplier's result ports and reduces them.

## Interface
Parameters:
- `N`, 8, operand width; must match the multiplier instance.
- `CNT_W`, 2*N+1, width of pair and event counters; holds 2^(2N).
- `SUM_W`, 2*N+8, width of the percent-error accumulator; holds 255·2^(2N).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `op_a`  out  N  operand A to the multiplier (registered).
- `op_b`  out  N  operand B to the multiplier (registered).
- `exact_product`  in  2N  multiplier exact result.
- `approx_product`  in  2N  multiplier approximate result.
- `percent_error`  in  8  multiplier percent error.
- `error_flag`  in  1  multiplier error flag.
- `busy`  out  1  high while the sweep is in progress.
- `done`  out  1  one-cycle pulse at sweep completion.
- `pair_count`  out  CNT_W  pairs sampled.
- `flag_count`  out  CNT_W  pairs with `error_flag`=1.
- `mismatch_count`  out  CNT_W  pairs with approx ≠ exact.
- `err_sum`  out  SUM_W  sum of `percent_error`.
- `max_err`  out  8  largest `percent_error` seen.
- `max_err_a`, `max_err_b`  out  N each  operands that produced `max_err`.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE
  - `busy`=0.
  - Statistics hold their last values.
  - `start`=1 clears all statistics, sets `op_a`=`op_b`=0 and moves to DRIVE.
- DRIVE
  - Operands are stable.
  - The combinational multiplier result settles.
  - Nothing is accumulated.
  - Next state is SAMPLE.
- SAMPLE: on this edge, accumulate:
  - `pair_count` += 1.
  - `flag_count` += `error_flag`.
  - `mismatch_count` += (`approx_product` != `exact_product`).
  - `err_sum` += `percent_error`, zero-extended.
  - If `percent_error` > `max_err` (strictly greater), update `max_err`, `max_err_a`←`op_a` and `max_err_b`←`op_b`.
- Operand advance in SAMPLE:
  - `op_b` is the inner loop and `op_a` the outer loop.
  - If `op_b` < 2^N−1: `op_b`+1, then go to DRIVE.
  - Else `op_b`←0. If `op_a` < 2^N−1: `op_a`+1, then go to DRIVE.
  - Else (last pair (2^N−1, 2^N−1) sampled): go to DONE. The operands wrap to 0 and 0.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- Tie rule: the first occurrence in sweep order keeps `max_err` and its operands. If every error is 0, `max_err_a`=`max_err_b`=0.
- `start` outside IDLE is ignored. There is no abort input; `rst` is the only abort.
- Counters cannot overflow at the given widths, so no saturation logic is needed.

## Timing
- Reset (`rst`=1 at an edge) takes effect from any state, including mid-sweep, and returns to IDLE.
- Reset values: `op_a`=0, `op_b`=0, `busy`=0, `done`=0, all counters 0, `err_sum`=0, `max_err`=0, `max_err_a`=0, `max_err_b`=0.
- Let P = 2^(2N) and let `start` be sampled at edge 0:
  - Cycles 1..2P: `busy`=1. Pair k is driven in cycle 2k+1 and sampled at the end of cycle 2k+2.
  - Cycle 2P+1: `done`=1, `busy`=0, and all statistics are final.
  - Cycle 2P+2: IDLE. A new `start` is accepted here.
- Throughput: 2 cycles per pair. The multiplier gets one full clock period of combinational settling.
- Statistics update only on SAMPLE edges. Intermediate values are visible while `busy`=1.
- `start` held high continuously restarts the sweep immediately after each DONE.

## Test plan
- Reset
  - Stimulus: `rst` high for 2 cycles, with `start` high at the same time.
  - Required response: every output equals its reset value and `busy` stays 0 while `rst`=1.
- Exact model, N=2
  - Stimulus: bench stub sets approx=exact=`op_a`·`op_b`, pct=0, flag=0; pulse `start`.
  - Required response: `done` in cycle 33; `pair_count`=16; `flag_count`=0; `mismatch_count`=0; `err_sum`=0; `max_err`=0 at (0,0).
- Graded-error stub, N=2
  - Stimulus: pct={`op_a`,`op_b`} (values 0..15); flag=(pct>10); approx=exact+(pct!=0).
  - Required response: `err_sum`=120, `flag_count`=5, `mismatch_count`=15, `max_err`=15 with `max_err_a`=3 and `max_err_b`=3.
- Tie and ordering
  - Stimulus: pct constant 7.
  - Required response: `max_err`=7 with `max_err_a`=0 and `max_err_b`=0; `err_sum`=112. Operand trace is (0,0),(0,1),(0,2),(0,3),(1,0)…
- Abort and restart
  - Stimulus: reset at cycle 10 of the graded sweep, then pulse `start`. Also pulse `start` again during that sweep.
  - Required response: after the reset, all outputs are at reset values and the block is idle. The `start` during the sweep is ignored. Final results are identical to the graded-error scenario, with `done` exactly 33 cycles after the accepted start.
- Full N=8 with the real multiplier
  - Stimulus: full sweep.
  - Required response: `pair_count`=65536 and `done` in cycle 131073. All statistics match the bench's software accumulation over the same 65536 pairs.

Source files
------------

// File: rtl/mult_error_sweeper_if.sv
// Bundle between the error sweeper and its environment: operand drive to the
// multiplier, the multiplier's result ports, the start request and the
// accumulated statistics read back by the display/readout logic.
interface mult_error_sweeper_if #(
    parameter int N     = 8,
    parameter int CNT_W = 2 * N + 1,
    parameter int SUM_W = 2 * N + 8
);
    // Control
    logic             start;
    logic             busy;
    logic             done;

    // Operands towards the multiplier and its results back
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [2*N-1:0]   exact_product;
    logic [2*N-1:0]   approx_product;
    logic [7:0]       percent_error;
    logic             error_flag;

    // Statistics
    logic [CNT_W-1:0] pair_count;
    logic [CNT_W-1:0] flag_count;
    logic [CNT_W-1:0] mismatch_count;
    logic [SUM_W-1:0] err_sum;
    logic [7:0]       max_err;
    logic [N-1:0]     max_err_a;
    logic [N-1:0]     max_err_b;

    // The sweeper drives operands and statistics and consumes the results.
    modport master (
        input  start,
        input  exact_product,
        input  approx_product,
        input  percent_error,
        input  error_flag,
        output op_a,
        output op_b,
        output busy,
        output done,
        output pair_count,
        output flag_count,
        output mismatch_count,
        output err_sum,
        output max_err,
        output max_err_a,
        output max_err_b
    );

    // The environment (multiplier plus readout) sees the mirror image.
    modport slave (
        output start,
        output exact_product,
        output approx_product,
        output percent_error,
        output error_flag,
        input  op_a,
        input  op_b,
        input  busy,
        input  done,
        input  pair_count,
        input  flag_count,
        input  mismatch_count,
        input  err_sum,
        input  max_err,
        input  max_err_a,
        input  max_err_b
    );
endinterface

// File: rtl/mult_error_sweeper.sv
// Exhaustive operand sweeper for the approximate multiplier. Each pair gets a
// DRIVE cycle (operands stable, multiplier settles) and a SAMPLE cycle whose
// closing edge folds the multiplier's results into the running statistics.
// op_b is the inner loop, op_a the outer loop.
module mult_error_sweeper #(
    parameter int N     = 8,
    parameter int CNT_W = 2 * N + 1,
    parameter int SUM_W = 2 * N + 8
) (
    input  logic                clk,
    input  logic                rst,
    mult_error_sweeper_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [N-1:0] OP_MAX = {N{1'b1}};

    state_t           stateReg;
    logic [N-1:0]     opAReg;
    logic [N-1:0]     opBReg;
    logic             busyReg;
    logic             doneReg;
    logic [CNT_W-1:0] pairCountReg;
    logic [CNT_W-1:0] flagCountReg;
    logic [CNT_W-1:0] mismatchCountReg;
    logic [SUM_W-1:0] errSumReg;
    logic [7:0]       maxErrReg;
    logic [N-1:0]     maxErrAReg;
    logic [N-1:0]     maxErrBReg;

    // Per-pair contributions, widened to the accumulator widths.
    logic [CNT_W-1:0] flagInc;
    logic [CNT_W-1:0] mismatchInc;
    logic [SUM_W-1:0] errInc;
    logic             newMax;

    // Result decoding for the pair currently on the operand bus.
    always_comb begin
        flagInc     = CNT_W'(bus.error_flag);
        mismatchInc = CNT_W'(bus.approx_product != bus.exact_product);
        errInc      = SUM_W'(bus.percent_error);
        // Strictly greater keeps the first occurrence on ties.
        newMax      = (bus.percent_error > maxErrReg);
    end

    // Sweep sequencer, operand generator and statistics accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg         <= ST_IDLE;
            opAReg           <= '0;
            opBReg           <= '0;
            busyReg          <= 1'b0;
            doneReg          <= 1'b0;
            pairCountReg     <= '0;
            flagCountReg     <= '0;
            mismatchCountReg <= '0;
            errSumReg        <= '0;
            maxErrReg        <= '0;
            maxErrAReg       <= '0;
            maxErrBReg       <= '0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                    if (bus.start) begin
                        // Statistics from the previous sweep are kept until
                        // the next one is actually launched.
                        pairCountReg     <= '0;
                        flagCountReg     <= '0;
                        mismatchCountReg <= '0;
                        errSumReg        <= '0;
                        maxErrReg        <= '0;
                        maxErrAReg       <= '0;
                        maxErrBReg       <= '0;
                        opAReg           <= '0;
                        opBReg           <= '0;
                        busyReg          <= 1'b1;
                        stateReg         <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    // Operands were updated on the previous edge; give the
                    // multiplier this whole period to settle.
                    stateReg <= ST_SAMPLE;
                end

                ST_SAMPLE: begin
                    pairCountReg     <= pairCountReg + CNT_W'(1);
                    flagCountReg     <= flagCountReg + flagInc;
                    mismatchCountReg <= mismatchCountReg + mismatchInc;
                    errSumReg        <= errSumReg + errInc;
                    if (newMax) begin
                        maxErrReg  <= bus.percent_error;
                        maxErrAReg <= opAReg;
                        maxErrBReg <= opBReg;
                    end

                    if (opBReg != OP_MAX) begin
                        opBReg   <= opBReg + N'(1);
                        stateReg <= ST_DRIVE;
                    end else begin
                        opBReg <= '0;
                        if (opAReg != OP_MAX) begin
                            opAReg   <= opAReg + N'(1);
                            stateReg <= ST_DRIVE;
                        end else begin
                            // Last pair sampled: operands wrap to (0,0).
                            opAReg   <= '0;
                            busyReg  <= 1'b0;
                            doneReg  <= 1'b1;
                            stateReg <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    doneReg  <= 1'b0;
                    stateReg <= ST_IDLE;
                end

                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.op_a           = opAReg;
    assign bus.op_b           = opBReg;
    assign bus.busy           = busyReg;
    assign bus.done           = doneReg;
    assign bus.pair_count     = pairCountReg;
    assign bus.flag_count     = flagCountReg;
    assign bus.mismatch_count = mismatchCountReg;
    assign bus.err_sum        = errSumReg;
    assign bus.max_err        = maxErrReg;
    assign bus.max_err_a      = maxErrAReg;
    assign bus.max_err_b      = maxErrBReg;

endmodule

// File: tb/tb_mult_error_sweeper.sv
// Bench for mult_error_sweeper: an N=2 instance driven by selectable result
// stubs and checked every cycle against a sweep-timeline model, plus an N=4
// instance fed by a truncating multiplier and checked against a software
// accumulation at completion.
module tb_mult_error_sweeper;

    localparam int N2   = 2;
    localparam int P2   = 16;
    localparam int LAST = 2 * P2 + 1;   // done cycle for N=2
    localparam int N4   = 4;

    logic clk = 1'b0;
    logic rst;
    int   mode;        // 0 exact, 1 graded, 2 constant 7
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mult_error_sweeper_if #(.N(N2)) bus ();
    mult_error_sweeper_if #(.N(N4)) bus4 ();

    mult_error_sweeper #(.N(N2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    mult_error_sweeper #(.N(N4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.master)
    );

    // ---------------- result stubs ----------------
    function automatic int f_pct(input int md, input int a, input int b);
        if (md == 1) return a * 4 + b;
        if (md == 2) return 7;
        return 0;
    endfunction

    function automatic int f_flag(input int md, input int pct);
        return (md == 1 && pct > 10) ? 1 : 0;
    endfunction

    function automatic int f_approx(input int md, input int a, input int b);
        return (md == 1 && f_pct(md, a, b) != 0) ? a * b + 1 : a * b;
    endfunction

    assign bus.exact_product  = 4'(int'(bus.op_a) * int'(bus.op_b));
    assign bus.approx_product = 4'(f_approx(mode, int'(bus.op_a), int'(bus.op_b)));
    assign bus.percent_error  = 8'(f_pct(mode, int'(bus.op_a), int'(bus.op_b)));
    assign bus.error_flag     = 1'(f_flag(mode, f_pct(mode, int'(bus.op_a), int'(bus.op_b))));

    // Truncating multiplier for the N=4 instance: low two product bits dropped.
    function automatic int m4_exact(input int a, input int b);
        return a * b;
    endfunction
    function automatic int m4_approx(input int a, input int b);
        return (a * b) & ~3;
    endfunction
    function automatic int m4_pct(input int a, input int b);
        int e;
        e = a * b;
        return (e == 0) ? 0 : ((e - m4_approx(a, b)) * 100) / e;
    endfunction

    assign bus4.exact_product  = 8'(m4_exact(int'(bus4.op_a), int'(bus4.op_b)));
    assign bus4.approx_product = 8'(m4_approx(int'(bus4.op_a), int'(bus4.op_b)));
    assign bus4.percent_error  = 8'(m4_pct(int'(bus4.op_a), int'(bus4.op_b)));
    assign bus4.error_flag     = (m4_pct(int'(bus4.op_a), int'(bus4.op_b)) > 20);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model for the N=2 instance ----------------
    // m_cyc = 0 when idle, otherwise the cycle number since the accepted start.
    int m_cyc = 0;
    bit m_valid = 1'b0;
    int m_pairs, m_flags, m_mis, m_sum, m_max, m_maxa, m_maxb;

    task automatic model_clear();
        m_pairs = 0; m_flags = 0; m_mis = 0; m_sum = 0;
        m_max = 0; m_maxa = 0; m_maxb = 0;
    endtask

    always @(posedge clk) begin
        int k, a, b, pc;
        if (rst) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            model_clear();
        end else if (m_valid) begin
            if (m_cyc == 0) begin
                if (bus.start) begin
                    m_cyc = 1;
                    model_clear();
                end
            end else if (m_cyc == LAST) begin
                m_cyc = 0;
            end else begin
                if (m_cyc % 2 == 0) begin
                    k  = (m_cyc - 2) / 2;
                    a  = k / 4;
                    b  = k % 4;
                    pc = f_pct(mode, a, b);
                    m_pairs++;
                    m_flags += f_flag(mode, pc);
                    m_mis   += (f_approx(mode, a, b) != a * b) ? 1 : 0;
                    m_sum   += pc;
                    if (pc > m_max) begin
                        m_max = pc; m_maxa = a; m_maxb = b;
                    end
                end
                m_cyc++;
            end
        end
        #1;
        if (m_valid) begin
            int ea, eb, ebusy;
            ebusy = (m_cyc >= 1 && m_cyc <= 2 * P2) ? 1 : 0;
            ea = 0; eb = 0;
            if (ebusy == 1) begin
                ea = ((m_cyc - 1) / 2) / 4;
                eb = ((m_cyc - 1) / 2) % 4;
            end
            check("busy",      64'(bus.busy),           64'(ebusy));
            check("done",      64'(bus.done),           64'(m_cyc == LAST));
            check("op_a",      64'(bus.op_a),           64'(ea));
            check("op_b",      64'(bus.op_b),           64'(eb));
            check("pair_cnt",  64'(bus.pair_count),     64'(m_pairs));
            check("flag_cnt",  64'(bus.flag_count),     64'(m_flags));
            check("mis_cnt",   64'(bus.mismatch_count), 64'(m_mis));
            check("err_sum",   64'(bus.err_sum),        64'(m_sum));
            check("max_err",   64'(bus.max_err),        64'(m_max));
            check("max_err_a", 64'(bus.max_err_a),      64'(m_maxa));
            check("max_err_b", 64'(bus.max_err_b),      64'(m_maxb));
        end
    end

    // ---------------- directed helpers ----------------
    int tra[5];
    int trb[5];

    // Pulse start, optionally pulse it again at cycle pulse_at or reset at
    // cycle abort_at; returns the cycle in which done was seen (-1 if none).
    task automatic run_sweep(input int pulse_at, input int abort_at, output int done_cyc);
        done_cyc = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c % 2 == 1 && (c - 1) / 2 < 5) begin
                tra[(c - 1) / 2] = int'(bus.op_a);
                trb[(c - 1) / 2] = int'(bus.op_b);
            end
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
                return;
            end
            bus.start = (c == pulse_at);
            if (bus.done) begin
                done_cyc = c;
                bus.start = 1'b0;
                return;
            end
            @(posedge clk);
            #2;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int pairs, input int flags,
                               input int mis, input int sum, input int mx,
                               input int ma, input int mb);
        check({tag, "_pairs"}, 64'(bus.pair_count),     64'(pairs));
        check({tag, "_flags"}, 64'(bus.flag_count),     64'(flags));
        check({tag, "_mis"},   64'(bus.mismatch_count), 64'(mis));
        check({tag, "_sum"},   64'(bus.err_sum),        64'(sum));
        check({tag, "_max"},   64'(bus.max_err),        64'(mx));
        check({tag, "_maxa"},  64'(bus.max_err_a),      64'(ma));
        check({tag, "_maxb"},  64'(bus.max_err_b),      64'(mb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int s_pairs, s_flags, s_mis, s_sum, s_max, s_ma, s_mb;
        mode       = 0;
        bus4.start = 1'b0;

        // Reset held two cycles with start asserted.
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #2;
        check("rst_busy1", 64'(bus.busy), 64'd0);
        @(posedge clk); #2;
        check("rst_busy2", 64'(bus.busy), 64'd0);
        check("rst_done",  64'(bus.done), 64'd0);
        check_stats("rst", 0, 0, 0, 0, 0, 0, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #2;

        // Exact model.
        mode = 0;
        run_sweep(0, 0, dc);
        check("exact_done_cyc", 64'(dc), 64'd33);
        check_stats("exact", 16, 0, 0, 0, 0, 0, 0);
        $display("[TB] exact sweep done_cycle=%0d pairs=%0d", dc, bus.pair_count);
        @(posedge clk); #2;

        // Graded-error stub.
        mode = 1;
        run_sweep(0, 0, dc);
        check("graded_done_cyc", 64'(dc), 64'd33);
        check_stats("graded", 16, 5, 15, 120, 15, 3, 3);
        $display("[TB] graded sweep done_cycle=%0d err_sum=%0d", dc, bus.err_sum);
        @(posedge clk); #2;
        check("graded_hold_sum", 64'(bus.err_sum), 64'd120);

        // Tie and ordering.
        mode = 2;
        run_sweep(0, 0, dc);
        check("tie_done_cyc", 64'(dc), 64'd33);
        check_stats("tie", 16, 0, 0, 112, 7, 0, 0);
        check("trace0_a", 64'(tra[0]), 64'd0); check("trace0_b", 64'(trb[0]), 64'd0);
        check("trace1_a", 64'(tra[1]), 64'd0); check("trace1_b", 64'(trb[1]), 64'd1);
        check("trace2_a", 64'(tra[2]), 64'd0); check("trace2_b", 64'(trb[2]), 64'd2);
        check("trace3_a", 64'(tra[3]), 64'd0); check("trace3_b", 64'(trb[3]), 64'd3);
        check("trace4_a", 64'(tra[4]), 64'd1); check("trace4_b", 64'(trb[4]), 64'd0);
        $display("[TB] tie sweep done_cycle=%0d max_err=%0d", dc, bus.max_err);
        @(posedge clk); #2;

        // Abort at cycle 10 of a graded sweep, then restart with a stray start.
        mode = 1;
        run_sweep(0, 10, dc);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_opa",  64'(bus.op_a), 64'd0);
        check("abort_opb",  64'(bus.op_b), 64'd0);
        check_stats("abort", 0, 0, 0, 0, 0, 0, 0);
        $display("[TB] abort reset applied, busy=%0d", bus.busy);
        @(posedge clk); #2;
        run_sweep(20, 0, dc);
        check("restart_done_cyc", 64'(dc), 64'd33);
        check_stats("restart", 16, 5, 15, 120, 15, 3, 3);
        $display("[TB] restart sweep done_cycle=%0d err_sum=%0d", dc, bus.err_sum);
        @(posedge clk); #2;

        // start held high: back-to-back sweeps, checked cycle by cycle.
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        dc = -1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #2;
            if (bus.done) begin
                dc = c;
                break;
            end
        end
        check("held_second_done_seen", 64'(dc >= 0), 64'd1);
        check("held_pairs", 64'(bus.pair_count), 64'd16);
        $display("[TB] held-start second sweep finished, pairs=%0d", bus.pair_count);
        @(posedge clk); #2;

        // N=4 sweep with a truncating multiplier vs software accumulation.
        s_pairs = 0; s_flags = 0; s_mis = 0; s_sum = 0; s_max = 0; s_ma = 0; s_mb = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int pc;
                pc = m4_pct(a, b);
                s_pairs++;
                s_flags += (pc > 20) ? 1 : 0;
                s_mis   += (m4_approx(a, b) != m4_exact(a, b)) ? 1 : 0;
                s_sum   += pc;
                if (pc > s_max) begin
                    s_max = pc; s_ma = a; s_mb = b;
                end
            end
        end
        // Pin the software accumulation: first exact==1 pair (1,1) gives 100%.
        check("sw4_max", 64'(s_max), 64'd100);
        check("sw4_maxa", 64'(s_ma), 64'd1);
        @(negedge clk);
        bus4.start = 1'b1;
        @(posedge clk); #2;
        bus4.start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 1000; c++) begin
            if (bus4.done) begin
                dc = c;
                break;
            end
            @(posedge clk); #2;
        end
        check("n4_done_cyc", 64'(dc), 64'd513);
        check("n4_pairs",  64'(bus4.pair_count),     64'(s_pairs));
        check("n4_flags",  64'(bus4.flag_count),     64'(s_flags));
        check("n4_mis",    64'(bus4.mismatch_count), 64'(s_mis));
        check("n4_sum",    64'(bus4.err_sum),        64'(s_sum));
        check("n4_max",    64'(bus4.max_err),        64'(s_max));
        check("n4_maxa",   64'(bus4.max_err_a),      64'(s_ma));
        check("n4_maxb",   64'(bus4.max_err_b),      64'(s_mb));
        $display("[TB] n4 sweep done_cycle=%0d pairs=%0d err_sum=%0d", dc, bus4.pair_count, bus4.err_sum);
        repeat (2) @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
